// File: rtl/router_output_arbiter_pkg.sv
// Shared NoC constants for the router output arbiter: packet layout, port
// indices, VC encoding and the round-robin pointer helper.
package router_output_arbiter_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int VC_BIT     = 63;
  localparam int NUM_VC     = 2;

  localparam int PORT_PE   = 0;
  localparam int PORT_W    = 1;
  localparam int PORT_E    = 2;
  localparam int PORT_N    = 3;
  localparam int PORT_S    = 4;
  localparam int NUM_PORTS = 5;

  // Packet layout: [63] VC, [62:60] direction, [59:56] hop, [55:48] source, [47:0] payload
  localparam int VC_LSB      = VC_BIT;
  localparam int DIR_LSB     = 60;
  localparam int DIR_W       = 3;
  localparam int HOP_LSB     = 56;
  localparam int HOP_W       = 4;
  localparam int SRC_LSB     = 48;
  localparam int SRC_W       = 8;
  localparam int PAYLOAD_LSB = 0;
  localparam int PAYLOAD_W   = 48;

  typedef enum logic {
    VC_EVEN = 1'b0,
    VC_ODD  = 1'b1
  } vc_e;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

  function automatic vc_e pkt_vc(input logic [DATA_WIDTH-1:0] pkt);
    return vc_e'(pkt[VC_BIT]);
  endfunction

endpackage

// File: rtl/router_output_arbiter_if.sv
// Request side and link side of one router output port.
// Handshakes: requester i holds req[i] (valid) until it sees gnt[i] (ready);
// the packet transfers at the clock edge where both are high. On the link,
// so is only raised while ro is high, so every edge with so=1 is a transfer.
interface router_output_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_vc;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic                          so;
  logic                          ro;
  logic [DATA_WIDTH-1:0]         link_data;

  modport slave (
    input  req, req_vc, req_data, ro,
    output gnt, so, link_data
  );

  modport master (
    output req, req_vc, req_data, ro,
    input  gnt, so, link_data
  );
endinterface

// File: rtl/router_output_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first requester found scanning from ptr
// upward, modulo N.
module router_output_arbiter_rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  input  logic          enable_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] winner_o,
  output logic          valid_o
);

  logic [PW-1:0] idx;

  always_comb begin
    gnt_o    = '0;
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = '0;
    if (enable_i) begin
      for (int k = 0; k < N; k++) begin
        idx = PW'((int'(ptr_i) + k) % N);
        if (!valid_o && req_i[idx]) begin
          valid_o       = 1'b1;
          winner_o      = idx;
          gnt_o[idx]    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/router_output_arbiter.sv
// Output-port arbiter: grants one VC per cycle into its one-entry buffer while
// the other VC's buffer drains to the link; the phase follows polarity.
module router_output_arbiter
  import router_output_arbiter_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = router_output_arbiter_pkg::DATA_WIDTH,
  localparam int PW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   polarity,
  router_output_arbiter_if.slave link,
  output logic [NUM_VC-1:0]      dbg_obuf_v_o,
  output logic [NUM_VC*PW-1:0]   dbg_ptr_o
);

  logic [NUM_VC-1:0]                 obuf_v_q, obuf_v_d;
  logic [NUM_VC-1:0][DATA_WIDTH-1:0] obuf_d_q, obuf_d_d;
  logic [NUM_VC-1:0][PW-1:0]         ptr_q, ptr_d;

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_pkt;
  logic [NUM_VC-1:0][NUM_REQ-1:0]     arb_req;
  logic [NUM_VC-1:0][NUM_REQ-1:0]     arb_gnt;
  logic [NUM_VC-1:0][PW-1:0]          arb_winner;
  logic [NUM_VC-1:0]                  arb_valid;
  logic [NUM_VC-1:0]                  arb_en;

  vc_e  grant_vc;
  vc_e  send_vc;
  logic send_fire;

  assign grant_vc = vc_e'(polarity);
  assign send_vc  = vc_e'(~polarity);
  assign req_pkt  = link.req_data;

  genvar g;
  generate
    for (g = 0; g < NUM_VC; g++) begin : g_vc
      localparam logic VC = 1'(g);

      assign arb_req[g] = link.req & (VC ? link.req_vc : ~link.req_vc);
      // Outputs are gated by reset so gnt drops the moment reset rises.
      assign arb_en[g]  = !reset && (polarity == VC) && !obuf_v_q[g];

      router_output_arbiter_rr_arbiter #(
        .N (NUM_REQ)
      ) u_rr (
        .req_i    (arb_req[g]),
        .ptr_i    (ptr_q[g]),
        .enable_i (arb_en[g]),
        .gnt_o    (arb_gnt[g]),
        .winner_o (arb_winner[g]),
        .valid_o  (arb_valid[g])
      );
    end
  endgenerate

  assign link.gnt       = arb_gnt[grant_vc];
  assign send_fire      = !reset && obuf_v_q[send_vc] && link.ro;
  assign link.so        = send_fire;
  assign link.link_data = send_fire ? obuf_d_q[send_vc] : '0;

  // Only the grant-phase VC can have arb_valid set, and send always touches
  // the other VC, so the two updates never collide on one entry.
  always_comb begin
    obuf_v_d = obuf_v_q;
    obuf_d_d = obuf_d_q;
    ptr_d    = ptr_q;
    for (int v = 0; v < NUM_VC; v++) begin
      if (arb_valid[v]) begin
        obuf_v_d[v] = 1'b1;
        obuf_d_d[v] = req_pkt[arb_winner[v]];
        ptr_d[v]    = PW'(rr_next(int'(arb_winner[v]), NUM_REQ));
      end
    end
    if (send_fire) begin
      obuf_v_d[send_vc] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      obuf_v_q <= '0;
      obuf_d_q <= '0;
      ptr_q    <= '0;
    end else begin
      obuf_v_q <= obuf_v_d;
      obuf_d_q <= obuf_d_d;
      ptr_q    <= ptr_d;
    end
  end

  assign dbg_obuf_v_o = obuf_v_q;
  assign dbg_ptr_o    = ptr_q;

endmodule

// File: tb/tb_router_output_arbiter.sv
// Directed bench for router_output_arbiter: single packet, round-robin,
// VC interleave, back-pressure and asynchronous reset.
module tb_router_output_arbiter;

  localparam int NR = 4;
  localparam int DW = 64;
  localparam int PW = 2;

  logic clk = 1'b0;
  logic reset;
  logic polarity;
  logic [1:0]      dbg_obuf_v;
  logic [2*PW-1:0] dbg_ptr;

  logic [DW-1:0] pkt [NR];
  logic [DW-1:0] exp_q[$];
  int n_total = 0;
  int n_bad   = 0;

  router_output_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) link_if ();

  router_output_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .polarity     (polarity),
    .link         (link_if),
    .dbg_obuf_v_o (dbg_obuf_v),
    .dbg_ptr_o    (dbg_ptr)
  );

  assign link_if.req_data = {pkt[3], pkt[2], pkt[1], pkt[0]};

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timed out");
  end

  // checking
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic do_reset();
    reset          = 1'b1;
    polarity       = 1'b0;
    link_if.req    = '0;
    link_if.req_vc = '0;
    link_if.ro     = 1'b0;
    for (int i = 0; i < NR; i++) pkt[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    polarity = ~polarity;
  endtask

  task automatic set_req(input logic [NR-1:0] r, input logic [NR-1:0] vc);
    link_if.req    = r;
    link_if.req_vc = vc;
  endtask

  // scoreboard: link data is taken from exp_q whenever so is expected
  task automatic expect_cycle(input string tag, input logic [NR-1:0] g, input logic s);
    logic [DW-1:0] d;
    @(negedge clk);
    chk({tag, "_gnt"}, 64'(link_if.gnt), 64'(g));
    chk({tag, "_so"}, 64'(link_if.so), 64'(s));
    if (s) begin
      d = (exp_q.size() > 0) ? exp_q.pop_front() : {DW{1'b1}};
      chk({tag, "_do"}, link_if.link_data, d);
    end else begin
      chk({tag, "_do"}, link_if.link_data, 64'd0);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int i, input int n);
    return 64'h0000_00A0_0000_0000 | (64'(i) << 16) | 64'(n);
  endfunction

  logic [NR-1:0] rr_tab [5];
  int w;

  initial begin
    rr_tab[0] = 4'b0001; rr_tab[1] = 4'b0010; rr_tab[2] = 4'b0100;
    rr_tab[3] = 4'b1000; rr_tab[4] = 4'b0001;

    // reset held with everyone requesting: nothing may come out
    reset    = 1'b1;
    polarity = 1'b0;
    link_if.ro = 1'b1;
    for (int i = 0; i < NR; i++) pkt[i] = mk(i, 0);
    set_req(4'b1111, 4'b0000);
    expect_cycle("rst_hold", 4'b0000, 1'b0);
    chk("rst_obuf_v", 64'(dbg_obuf_v), 64'd0);
    chk("rst_ptr", 64'(dbg_ptr), 64'd0);

    // single packet
    do_reset();
    link_if.ro = 1'b1;
    pkt[1] = 64'h0000_0100_1111_1111;
    set_req(4'b0010, 4'b0000);
    exp_q.push_back(64'h0000_0100_1111_1111);
    expect_cycle("t1_grant", 4'b0010, 1'b0);
    next_cycle();
    set_req(4'b0000, 4'b0000);
    expect_cycle("t1_send", 4'b0000, 1'b1);
    next_cycle();
    expect_cycle("t1_idle", 4'b0000, 1'b0);

    // round-robin on VC0
    do_reset();
    link_if.ro = 1'b1;
    for (int i = 0; i < NR; i++) pkt[i] = mk(i, 0);
    set_req(4'b1111, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      w = k % NR;
      exp_q.push_back(pkt[w]);
      expect_cycle("rr_grant", rr_tab[k], (k != 0) ? 1'b0 : 1'b0);
      next_cycle();
      pkt[w] = mk(w, k + 1);
      expect_cycle("rr_send", 4'b0000, 1'b1);
      next_cycle();
    end

    // VC interleave
    do_reset();
    link_if.ro = 1'b1;
    pkt[0] = 64'h8000_0000_2222_2222;
    pkt[1] = 64'h0000_0000_9999_9999;
    set_req(4'b0011, 4'b0001);
    exp_q.push_back(64'h0000_0000_9999_9999);
    expect_cycle("vc_c0", 4'b0010, 1'b0);
    next_cycle();
    exp_q.push_back(64'h8000_0000_2222_2222);
    expect_cycle("vc_c1", 4'b0001, 1'b1);
    next_cycle();
    exp_q.push_back(64'h0000_0000_9999_9999);
    expect_cycle("vc_c2", 4'b0010, 1'b1);
    next_cycle();
    exp_q.push_back(64'h8000_0000_2222_2222);
    expect_cycle("vc_c3", 4'b0001, 1'b1);
    next_cycle();
    set_req(4'b0000, 4'b0000);
    expect_cycle("vc_c4", 4'b0000, 1'b1);
    next_cycle();

    // back-pressure
    do_reset();
    link_if.ro = 1'b0;
    pkt[0] = 64'h0000_0000_AAAA_0001;
    set_req(4'b0001, 4'b0000);
    exp_q.push_back(64'h0000_0000_AAAA_0001);
    expect_cycle("bp_grant", 4'b0001, 1'b0);
    next_cycle();
    pkt[0] = 64'h0000_0000_AAAA_0002;
    for (int k = 0; k < 6; k++) begin
      expect_cycle("bp_stall", 4'b0000, 1'b0);
      next_cycle();
    end
    link_if.ro = 1'b1;
    expect_cycle("bp_drain", 4'b0000, 1'b1);
    next_cycle();
    exp_q.push_back(64'h0000_0000_AAAA_0002);
    expect_cycle("bp_regrant", 4'b0001, 1'b0);
    next_cycle();
    set_req(4'b0000, 4'b0000);
    expect_cycle("bp_send2", 4'b0000, 1'b1);
    next_cycle();

    // reset mid-operation with both buffers full and ptr[0]=2
    do_reset();
    link_if.ro = 1'b0;
    pkt[1] = 64'h0000_0000_CCCC_CCCC;
    set_req(4'b0010, 4'b0000);
    expect_cycle("rs_fill0", 4'b0010, 1'b0);
    next_cycle();
    pkt[2] = 64'h8000_0000_DDDD_DDDD;
    set_req(4'b0100, 4'b0100);
    expect_cycle("rs_fill1", 4'b0100, 1'b0);
    next_cycle();
    for (int i = 0; i < NR; i++) pkt[i] = mk(i, 7);
    set_req(4'b1111, 4'b0000);
    link_if.ro = 1'b1;
    exp_q.push_back(64'h8000_0000_DDDD_DDDD);
    expect_cycle("rs_pre", 4'b0000, 1'b1);
    chk("rs_pre_obuf_v", 64'(dbg_obuf_v), 64'd3);
    chk("rs_pre_ptr", 64'(dbg_ptr), 64'b1110);
    #2;
    reset = 1'b1;
    #1;
    chk("rs_async_so", 64'(link_if.so), 64'd0);
    chk("rs_async_gnt", 64'(link_if.gnt), 64'd0);
    chk("rs_async_do", link_if.link_data, 64'd0);
    chk("rs_async_obuf_v", 64'(dbg_obuf_v), 64'd0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    polarity = 1'b0;
    exp_q.push_back(pkt[0]);
    expect_cycle("rs_after", 4'b0001, 1'b0);
    next_cycle();
    set_req(4'b0000, 4'b0000);
    expect_cycle("rs_after_send", 4'b0000, 1'b1);

    chk("sb_left", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
